ifetch_assoc: RTL and testbench

Parametrised next-generation instruction fetch unit. It contains an N-way set-associative instruction cache with configurable block size, a configurable-depth 2-bit branch history table, and hit/miss performance counters. It sits between the memory controller and the instruction decoder, is redirected by the reorder buffer, and issues one instruction per cycle on a cache hit.

---
 rtl/ifetch_assoc.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ifetch_assoc.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_assoc.sv
// ifetch_assoc: instruction fetch unit with an N-way set-associative
// instruction cache, a 2-bit branch history table and hit/miss counters.
//
// Handshakes:
//   - Refill: mc_en is a level request. mc_pc stays stable while it is high.
//     The memory side answers with a one-cycle mc_done pulse carrying the
//     whole block on mc_data. The request drops on the following edge.
//   - Issue: inst_rdy qualifies inst/inst_pc/inst_pred_jump for exactly the
//     cycle it is high. Back-pressure arrives one cycle early on the
//     *_nxt_full inputs, so there is no ready signal on the issue side.
//   - rdy low freezes every register, including the request and counters.
module ifetch_assoc #(
    parameter int SETS        = 16,
    parameter int WAYS        = 2,
    parameter int BLK_WORDS   = 16,
    parameter int BHT_ENTRIES = 256,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     rs_nxt_full,
    input  logic                     lsb_nxt_full,
    input  logic                     rob_nxt_full,
    output logic                     inst_rdy,
    output logic [31:0]              inst,
    output logic [31:0]              inst_pc,
    output logic                     inst_pred_jump,
    output logic                     mc_en,
    output logic [31:0]              mc_pc,
    input  logic                     mc_done,
    input  logic [32*BLK_WORDS-1:0]  mc_data,
    input  logic                     rob_set_pc_en,
    input  logic [31:0]              rob_set_pc,
    input  logic                     rob_br,
    input  logic                     rob_br_jump,
    input  logic [31:0]              rob_br_pc,
    output logic [CNT_W-1:0]         perf_hit_cnt,
    output logic [CNT_W-1:0]         perf_miss_cnt
);

    localparam int OFF_W = $clog2(BLK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BHT_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    // Refill FSM state. Kept as a named enum so it can be probed by name.
    state_t state_q;
    state_t state_d;

    // Cache storage. Tags and data are not reset; valid bits guard them.
    logic [TAG_W-1:0]            tag_q  [SETS][WAYS];
    logic [31:0]                 data_q [SETS][WAYS][BLK_WORDS];
    logic [SETS-1:0][WAYS-1:0]   valid_q;
    logic [SETS-1:0][WAY_W-1:0]  rr_q;

    // Branch history: one 2-bit saturating counter per entry.
    logic [BHT_ENTRIES-1:0][1:0] bht_q;

    // Fetch program counter.
    logic [31:0] pc_q;

    // Victim way chosen at miss time, and whether it came from the pointer.
    logic [WAY_W-1:0] victim_q;
    logic             victim_rr_q;

    // Lookup fields of the current pc.
    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign off = pc_q[OFF_W+1:2];
    assign idx = pc_q[IDX_W+OFF_W+1:OFF_W+2];
    assign tag = pc_q[31:IDX_W+OFF_W+2];

    // Fields of the outstanding refill address, used when mc_done arrives.
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign fill_idx = mc_pc[IDX_W+OFF_W+1:OFF_W+2];
    assign fill_tag = mc_pc[31:IDX_W+OFF_W+2];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [31:0]      hit_word;

    // Tag compare across all ways of the indexed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_word = data_q[idx][hit_way][off];

    logic [WAY_W-1:0] victim_way;
    logic             victim_rr;

    // Victim choice: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        victim_way = rr_q[idx];
        victim_rr  = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                victim_way = WAY_W'(w);
                victim_rr  = 1'b0;
            end
        end
    end

    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [1:0]  bht_ctr;
    logic        pred_jump;
    logic [31:0] pred_pc;

    assign j_imm   = {{12{hit_word[31]}}, hit_word[19:12], hit_word[20],
                      hit_word[30:21], 1'b0};
    assign b_imm   = {{20{hit_word[31]}}, hit_word[7], hit_word[30:25],
                      hit_word[11:8], 1'b0};
    assign bht_ctr = bht_q[pc_q[BHT_W+1:2]];

    // Static JAL prediction, dynamic BRANCH prediction, else fall through.
    always_comb begin
        pred_jump = 1'b0;
        pred_pc   = pc_q + 32'd4;
        if (hit_word[6:0] == OP_JAL) begin
            pred_jump = 1'b1;
            pred_pc   = pc_q + j_imm;
        end else if ((hit_word[6:0] == OP_BRANCH) && (bht_ctr >= 2'd2)) begin
            pred_jump = 1'b1;
            pred_pc   = pc_q + b_imm;
        end
    end

    logic any_full;
    logic issue;

    assign any_full = rs_nxt_full || lsb_nxt_full || rob_nxt_full;
    assign issue    = !rob_set_pc_en && hit && (hit_word != 32'd0) && !any_full;

    logic miss_start;
    logic fill;

    // Refill FSM next-state: launch on a miss, finish on mc_done.
    always_comb begin
        state_d    = state_q;
        miss_start = 1'b0;
        fill       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit && !rob_set_pc_en) begin
                    state_d    = WAIT_MEM;
                    miss_start = 1'b1;
                end
            end
            WAIT_MEM: begin
                if (mc_done) begin
                    state_d = IDLE;
                    fill    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Refill FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // Refill request, refill address and latched victim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_en       <= 1'b0;
            mc_pc       <= 32'd0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
        end else if (rdy) begin
            if (miss_start) begin
                mc_en       <= 1'b1;
                mc_pc       <= {pc_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                victim_q    <= victim_way;
                victim_rr_q <= victim_rr;
            end else if (fill) begin
                mc_en <= 1'b0;
            end
        end
    end

    // Valid bits and round-robin pointers; the pointer only moves on eviction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else if (rdy && fill) begin
            valid_q[fill_idx][victim_q] <= 1'b1;
            if (victim_rr_q) begin
                if (rr_q[fill_idx] == WAY_W'(WAYS - 1)) begin
                    rr_q[fill_idx] <= '0;
                end else begin
                    rr_q[fill_idx] <= rr_q[fill_idx] + 1'b1;
                end
            end
        end
    end

    // Tag and block write of a completed refill (no reset on storage).
    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            tag_q[fill_idx][victim_q] <= fill_tag;
            for (int i = 0; i < BLK_WORDS; i++) begin
                data_q[fill_idx][victim_q][i] <= mc_data[32*i +: 32];
            end
        end
    end

    // Fetch: redirect wins, otherwise issue the hit word and follow prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= 32'd0;
            inst_rdy       <= 1'b0;
            inst           <= 32'd0;
            inst_pc        <= 32'd0;
            inst_pred_jump <= 1'b0;
        end else if (rdy) begin
            if (rob_set_pc_en) begin
                inst_rdy <= 1'b0;
                pc_q     <= rob_set_pc;
            end else if (issue) begin
                inst_rdy       <= 1'b1;
                inst           <= hit_word;
                inst_pc        <= pc_q;
                inst_pred_jump <= pred_jump;
                pc_q           <= pred_pc;
            end else begin
                inst_rdy <= 1'b0;
            end
        end
    end

    logic [BHT_W-1:0] br_idx;
    logic             unused_br_pc;

    assign br_idx       = rob_br_pc[BHT_W+1:2];
    assign unused_br_pc = ^{rob_br_pc[31:BHT_W+2], rob_br_pc[1:0]};

    // Branch history update from resolved branches, saturating at 0 and 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bht_q <= '0;
        end else if (rdy && rob_br) begin
            if (rob_br_jump) begin
                if (bht_q[br_idx] != 2'd3) begin
                    bht_q[br_idx] <= bht_q[br_idx] + 2'd1;
                end
            end else begin
                if (bht_q[br_idx] != 2'd0) begin
                    bht_q[br_idx] <= bht_q[br_idx] - 2'd1;
                end
            end
        end
    end

    // Performance counters: issued instructions and launched refills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else if (rdy) begin
            if (issue) begin
                perf_hit_cnt <= perf_hit_cnt + CNT_W'(1);
            end
            if (miss_start) begin
                perf_miss_cnt <= perf_miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_assoc.sv
// tb_ifetch_assoc: directed scenarios plus randomized traffic, checked each
// cycle against a behavioural model of the fetch unit.
module tb_ifetch_assoc;

  localparam int SETS      = 16;
  localparam int WAYS      = 2;
  localparam int BLK       = 16;
  localparam int BHT       = 256;
  localparam int CNT_W     = 32;
  localparam int OFF_BITS  = $clog2(BLK);
  localparam int IDX_BITS  = $clog2(SETS);
  localparam int MEM_WORDS = 1024;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              rdy = 1'b1;
  logic              rs_nxt_full = 1'b0;
  logic              lsb_nxt_full = 1'b0;
  logic              rob_nxt_full = 1'b0;
  logic              inst_rdy;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_pred_jump;
  logic              mc_en;
  logic [31:0]       mc_pc;
  logic              mc_done = 1'b0;
  logic [32*BLK-1:0] mc_data;
  logic              rob_set_pc_en = 1'b0;
  logic [31:0]       rob_set_pc = 32'd0;
  logic              rob_br = 1'b0;
  logic              rob_br_jump = 1'b0;
  logic [31:0]       rob_br_pc = 32'd0;
  logic [CNT_W-1:0]  perf_hit_cnt;
  logic [CNT_W-1:0]  perf_miss_cnt;

  ifetch_assoc #(
    .SETS(SETS), .WAYS(WAYS), .BLK_WORDS(BLK), .BHT_ENTRIES(BHT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .rs_nxt_full(rs_nxt_full), .lsb_nxt_full(lsb_nxt_full), .rob_nxt_full(rob_nxt_full),
    .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc), .inst_pred_jump(inst_pred_jump),
    .mc_en(mc_en), .mc_pc(mc_pc), .mc_done(mc_done), .mc_data(mc_data),
    .rob_set_pc_en(rob_set_pc_en), .rob_set_pc(rob_set_pc),
    .rob_br(rob_br), .rob_br_jump(rob_br_jump), .rob_br_pc(rob_br_pc),
    .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  // ---------------------------------------------------------------- memory
  logic [31:0] mem [MEM_WORDS];

  always_comb begin
    for (int i = 0; i < BLK; i++) begin
      mc_data[32*i +: 32] = mem[{mc_pc[11:OFF_BITS+2], OFF_BITS'(i)}];
    end
  end

  int mem_age = 0;
  int mem_lat = 0;
  int lat_fixed = -1;
  bit spurious = 1'b0;

  // ---------------------------------------------------------------- reference model
  logic [31:0] m_pc, m_inst, m_inst_pc, m_mc_pc, m_hits, m_misses;
  bit          m_inst_rdy, m_pred, m_mc_en, m_from_rr;
  int          m_vic;
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][BLK];
  int          m_rr    [SETS];
  int          m_bht   [BHT];

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_inst = 0; m_inst_pc = 0; m_mc_pc = 0; m_hits = 0; m_misses = 0;
    m_inst_rdy = 0; m_pred = 0; m_mc_en = 0; m_from_rr = 0; m_vic = 0;
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
    end
    for (int b = 0; b < BHT; b++) m_bht[b] = 0;
  endtask

  // One rising edge worth of behaviour, using the inputs present at the edge.
  task automatic model_step();
    int idx, off, way, bidx, base;
    logic [31:0] tg, word, nxt;
    bit jump, hit, issue;
    if (!rdy) return;
    off = int'((m_pc >> 2) % BLK);
    idx = int'((m_pc >> (2 + OFF_BITS)) % SETS);
    tg  = m_pc >> (2 + OFF_BITS + IDX_BITS);
    way = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[idx][w] && m_tag[idx][w] == tg) way = w;
    hit  = (way >= 0);
    word = hit ? m_data[idx][way][off] : 32'd0;
    nxt  = m_pc + 4;
    jump = 0;
    if (word[6:0] == 7'b1101111) begin
      nxt = m_pc + imm_j(word); jump = 1;
    end else if (word[6:0] == 7'b1100011 && m_bht[int'((m_pc >> 2) % BHT)] >= 2) begin
      nxt = m_pc + imm_b(word); jump = 1;
    end
    issue = !rob_set_pc_en && hit && word != 0 && !(rs_nxt_full || lsb_nxt_full || rob_nxt_full);
    // refill engine
    if (!m_mc_en) begin
      if (!hit && !rob_set_pc_en) begin
        m_mc_en  = 1;
        m_mc_pc  = m_pc & ~32'(BLK * 4 - 1);
        m_misses = m_misses + 1;
        m_vic = -1;
        for (int w = 0; w < WAYS; w++) if (!m_valid[idx][w] && m_vic < 0) m_vic = w;
        m_from_rr = (m_vic < 0);
        if (m_vic < 0) m_vic = m_rr[idx];
      end
    end else if (mc_done) begin
      bidx = int'((m_mc_pc >> (2 + OFF_BITS)) % SETS);
      base = int'((m_mc_pc >> 2) % MEM_WORDS);
      m_valid[bidx][m_vic] = 1;
      m_tag[bidx][m_vic]   = m_mc_pc >> (2 + OFF_BITS + IDX_BITS);
      for (int i = 0; i < BLK; i++) m_data[bidx][m_vic][i] = mem[base + i];
      if (m_from_rr) m_rr[bidx] = (m_rr[bidx] + 1) % WAYS;
      m_mc_en = 0;
    end
    // fetch
    if (rob_set_pc_en) begin
      m_inst_rdy = 0; m_pc = rob_set_pc;
    end else if (issue) begin
      m_inst_rdy = 1; m_inst = word; m_inst_pc = m_pc; m_pred = jump; m_pc = nxt;
      m_hits = m_hits + 1;
    end else begin
      m_inst_rdy = 0;
    end
    // branch history
    if (rob_br) begin
      bidx = int'((rob_br_pc >> 2) % BHT);
      if (rob_br_jump) m_bht[bidx] = (m_bht[bidx] == 3) ? 3 : m_bht[bidx] + 1;
      else             m_bht[bidx] = (m_bht[bidx] == 0) ? 0 : m_bht[bidx] - 1;
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("inst_rdy", 64'(inst_rdy), 64'(m_inst_rdy));
    if (m_inst_rdy) begin
      check("inst", 64'(inst), 64'(m_inst));
      check("inst_pc", 64'(inst_pc), 64'(m_inst_pc));
      check("pred_jump", 64'(inst_pred_jump), 64'(m_pred));
    end
    check("mc_en", 64'(mc_en), 64'(m_mc_en));
    if (m_mc_en) check("mc_pc", 64'(mc_pc), 64'(m_mc_pc));
    check("hit_cnt", 64'(perf_hit_cnt), 64'(m_hits));
    check("miss_cnt", 64'(perf_miss_cnt), 64'(m_misses));
  endtask

  // ---------------------------------------------------------------- driver tasks
  // Memory responder: answers a held request after mem_lat cycles and keeps
  // answering until the request drops (covers rdy-low cycles).
  task automatic respond();
    if (mc_en) begin
      if (mem_age == 0) mem_lat = (lat_fixed < 0) ? $urandom_range(0, 3) : lat_fixed;
      mc_done = (mem_age >= mem_lat);
      mem_age++;
    end else begin
      mem_age = 0;
      mc_done = spurious && ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    respond();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic idle_inputs();
    rdy = 1; rs_nxt_full = 0; lsb_nxt_full = 0; rob_nxt_full = 0;
    rob_set_pc_en = 0; rob_br = 0; rob_br_jump = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; idle_inputs(); mc_done = 0; mem_age = 0;
    repeat (2) @(posedge clk);
    #3;
    model_reset();
    rst_n = 1;
    compare_all();
  endtask

  task automatic redirect(input logic [31:0] target);
    rob_set_pc_en = 1; rob_set_pc = target;
    cycle();
    rob_set_pc_en = 0;
  endtask

  task automatic load_linear();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
  endtask

  function automatic logic [31:0] rand_inst();
    int k;
    logic [31:0] w;
    k = $urandom_range(0, 99);
    w = $urandom();
    if (k < 8)  return 32'd0;
    if (k < 18) return {w[31:7], 7'b1101111};
    if (k < 40) return {w[31:7], 7'b1100011};
    return {w[31:7], 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 1023)) << 2);
    if ($urandom_range(0, 15) == 0) t = t | 32'hFFFF_0000;
    return t;
  endfunction

  task automatic randomize_inputs();
    rdy           = ($urandom_range(0, 9) != 0);
    rs_nxt_full   = ($urandom_range(0, 19) == 0);
    lsb_nxt_full  = ($urandom_range(0, 19) == 0);
    rob_nxt_full  = ($urandom_range(0, 19) == 0);
    rob_set_pc_en = ($urandom_range(0, 24) == 0);
    rob_set_pc    = rand_target();
    rob_br        = ($urandom_range(0, 3) == 0);
    rob_br_jump   = ($urandom_range(0, 1) == 1);
    rob_br_pc     = $urandom();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    load_linear();
    do_reset();
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
    check("rst_pred", 64'(inst_pred_jump), 64'd0);
    check("rst_mc_pc", 64'(mc_pc), 64'd0);

    // linear block at 0x0..0x3C with a 3-cycle memory
    lat_fixed = 3;
    run(30);

    // same-set conflicts: 0x000, 0x400, back to 0x000, then 0x800 evicts way 0
    do_reset();
    lat_fixed = 1;
    run(8);
    redirect(32'h400); run(8);
    redirect(32'h000); run(5);
    redirect(32'h800); run(8);
    redirect(32'h000); run(8);
    redirect(32'h400); run(5);

    // redirect while a refill is outstanding
    do_reset();
    lat_fixed = 6;
    run(2);
    redirect(32'h100);
    run(15);

    // branch at 0x20 (BEQ +16) trained taken, then weakened
    mem[8] = 32'h0000_0863;
    do_reset();
    lat_fixed = 2;
    rob_br = 1; rob_br_pc = 32'h20; rob_br_jump = 1;
    run(2);
    rob_br = 0;
    redirect(32'h20); run(10);
    rob_br = 1; rob_br_jump = 0;
    cycle();
    rob_br = 0;
    redirect(32'h20); run(4);

    // stalls: full, rdy low, then a zero word in the stream
    rob_nxt_full = 1; run(4); rob_nxt_full = 0;
    rdy = 0; run(4); rdy = 1;
    mem[4] = 32'd0;
    do_reset();
    run(15);

    // asynchronous reset in the middle of a refill
    load_linear();
    do_reset();
    lat_fixed = 8;
    run(3);
    #2;
    rst_n = 0;
    #1;
    check("arst_mc_en", 64'(mc_en), 64'd0);
    check("arst_miss_cnt", 64'(perf_miss_cnt), 64'd0);
    do_reset();
    lat_fixed = 1;
    redirect(32'h000); run(6);

    // randomized traffic
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = rand_inst();
    do_reset();
    lat_fixed = -1;
    spurious = 1;
    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
